// File: rtl/gate_jump_ctrl.sv
// -----------------------------------------------------------------------------
// gate_jump_ctrl
// Decides when the frog teleports between gate A and gate B.
//
// Collision pulses are latched over a video frame and evaluated once per frame
// at startOfFrame. A jump produces a one-cycle jump_req strobe. The jump is
// followed by a cooldown of COOLDOWN_FRAMES frames. After that, the controller
// waits until the frog has spent a full frame clear of both gates. This stops
// the frog from bouncing straight back through the other gate.
//
// Ports:
//   CLK          system clock
//   RESET        asynchronous reset, active-high
//   startOfFrame one-cycle pulse per video frame
//   enable       game running; only gates new IDLE->JUMP decisions
//   collision_A  frog overlaps gate A (pulse or level, any cycle)
//   collision_B  frog overlaps gate B
//   control      destination gate select (0 = gate A, 1 = gate B), held
//   jump_req     one-cycle strobe to load the muxed jump coordinates
//   busy         high whenever the controller is not IDLE
//   jump_count   jumps taken since reset, saturating
// -----------------------------------------------------------------------------
module gate_jump_ctrl #(
    parameter int COOLDOWN_FRAMES = 30,
    parameter int CNT_W           = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             startOfFrame,
    input  logic             enable,
    input  logic             collision_A,
    input  logic             collision_B,
    output logic             control,
    output logic             jump_req,
    output logic             busy,
    output logic [CNT_W-1:0] jump_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        JUMP       = 2'd1,
        COOLDOWN   = 2'd2,
        WAIT_CLEAR = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_FRAMES);

    state_t           state_r, state_s;
    logic             hit_a_r, hit_b_r;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             control_r, control_s;
    logic             jump_req_r, jump_req_s;
    logic             busy_r, busy_s;
    logic [CNT_W-1:0] jump_count_r, jump_count_s;

    // Per-frame collision latches. A collision seen in the SOF cycle itself
    // is dropped, so each SOF decision sees only the frame that just ended.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_a_r <= 1'b0;
            hit_b_r <= 1'b0;
        end else if (startOfFrame) begin
            hit_a_r <= 1'b0;
            hit_b_r <= 1'b0;
        end else begin
            hit_a_r <= hit_a_r | collision_A;
            hit_b_r <= hit_b_r | collision_B;
        end
    end

    // Next-state logic and next values for the registered outputs.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        control_s    = control_r;
        jump_req_s   = 1'b0;
        jump_count_s = jump_count_r;

        case (state_r)
            IDLE: begin
                // Gate A has priority when both gates were touched.
                // jump_req and jump_count are updated on the edge that enters
                // JUMP, so they are both visible during the JUMP cycle.
                if (startOfFrame && enable && (hit_a_r || hit_b_r)) begin
                    state_s    = JUMP;
                    control_s  = hit_a_r;
                    jump_req_s = 1'b1;
                    if (jump_count_r != CNT_MAX) begin
                        jump_count_s = jump_count_r + CNT_ONE;
                    end else begin
                        jump_count_s = jump_count_r;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            JUMP: begin
                state_s = COOLDOWN;
                cnt_s   = COOLDOWN_LOAD;
            end
            COOLDOWN: begin
                if (startOfFrame) begin
                    if (cnt_r == CNT_ONE) begin
                        state_s = WAIT_CLEAR;
                    end else begin
                        cnt_s = cnt_r - CNT_ONE;
                    end
                end else begin
                    state_s = COOLDOWN;
                end
            end
            WAIT_CLEAR: begin
                if (startOfFrame && !hit_a_r && !hit_b_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_CLEAR;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State, cooldown counter and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            control_r    <= 1'b0;
            jump_req_r   <= 1'b0;
            busy_r       <= 1'b0;
            jump_count_r <= '0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            control_r    <= control_s;
            jump_req_r   <= jump_req_s;
            busy_r       <= busy_s;
            jump_count_r <= jump_count_s;
        end
    end

    assign control    = control_r;
    assign jump_req   = jump_req_r;
    assign busy       = busy_r;
    assign jump_count = jump_count_r;

endmodule

// File: doc/gate_jump_ctrl.md
Name: gate_jump_ctrl

Overview:
Decides when the frog teleports between gate A and gate B, and drives the gate-select and jump-strobe consumed by the jump coordinate mux and the frog-position logic. Collision pulses from the VGA collision detector are latched per frame and evaluated once per frame at startOfFrame. After each jump a frame-counted cooldown follows, then a wait until the frog has left both gates, so the frog cannot ping-pong between gates.

Parameters:
COOLDOWN_FRAMES, 30, frames ignored after a jump; legal range 1..255.
CNT_W, 8, width of the cooldown counter and the jump_count output.

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-high
startOfFrame  in  1  one-cycle pulse per video frame
enable  in  1  game running; gates new jumps only
collision_A  in  1  frog pixel overlaps gate A (any cycle, pulse or level)
collision_B  in  1  frog pixel overlaps gate B
control  out  1  destination gate select: 0 = gate A, 1 = gate B
jump_req  out  1  one-cycle strobe: load the muxed jump coordinates
busy  out  1  high whenever state is not IDLE
jump_count  out  CNT_W  jumps taken since reset; saturates at 2^CNT_W-1

Behaviour:
- Reset (asynchronous, any time, including mid-sequence):
  - state=IDLE, control=0, jump_req=0, busy=0, jump_count=0.
  - hitA/hitB latches cleared; cooldown counter cleared.
- Latches:
  - hitA/hitB set on any cycle where the matching collision input is high and startOfFrame is low.
  - Both latches cleared on every startOfFrame cycle, in every state.
  - A collision in the startOfFrame cycle itself is dropped; it belongs to neither frame.
  - Each SOF decision uses the latch values present before that SOF cycle, i.e. the frame that just ended.
- FSM states: IDLE, JUMP, COOLDOWN, WAIT_CLEAR. All outputs are registered.
- IDLE:
  - On startOfFrame with enable=1 and hitA=1, go to JUMP with control<=1 (touch A, exit at B).
  - Else on startOfFrame with enable=1 and hitB=1, go to JUMP with control<=0.
  - hitA and hitB both set: hitA has priority, control<=1.
  - enable=0: stay in IDLE; the latches are still cleared at each SOF.
- JUMP:
  - Lasts exactly one cycle with jump_req=1.
  - jump_count increments by 1 unless already saturated.
  - Next state COOLDOWN, counter<=COOLDOWN_FRAMES.
- COOLDOWN:
  - On each startOfFrame: if counter==1 go to WAIT_CLEAR, else decrement the counter.
  - Exactly COOLDOWN_FRAMES SOF pulses are spent here; collisions are ignored for decisions.
- WAIT_CLEAR:
  - On startOfFrame: if hitA==0 and hitB==0, go to IDLE; otherwise stay.
  - The first evaluated frame is the one starting at the SOF that entered WAIT_CLEAR.
- enable deasserted outside IDLE does not abort the sequence; it only blocks the next IDLE->JUMP.
- control holds its value from JUMP until the next JUMP or reset, keeping the mux output stable.
- jump_req is never high in two consecutive cycles.
- jump_req latency: rises 1 cycle after the deciding startOfFrame.

Test Plan:
- Reset mid-COOLDOWN (COOLDOWN_FRAMES=3, RESET pulsed after 1 SOF) -> all outputs 0, state IDLE; a new hitA plus SOF immediately produces a jump.
- collision_A pulse in frame 0, SOF -> next cycle jump_req=1 for 1 cycle, control=1, busy=1, jump_count=1.
- collision_B held through 6 frames, COOLDOWN_FRAMES=3:
  - expected: jump with control=0, 3 SOFs in COOLDOWN, then WAIT_CLEAR while B is still hit.
  - after B drops for one full frame: IDLE at the following SOF, no second jump_req.
- collision_A and collision_B in the same frame -> control=1, a single jump_req.
- collision_A arriving only in the SOF cycle, or enable=0 during hit frames -> no jump_req, busy stays 0.
- 260 isolated jumps (COOLDOWN_FRAMES=1, clear frames between them) -> jump_count stops at 255, and jump_req still pulses on each jump.
